// File: rtl/mprj_io_ctrl_pkg.sv
// Shared constants for the pad control layer.
// Each pad owns one CFG_W-bit configuration word; the offsets below name its fields.
package mprj_io_ctrl_pkg;

    localparam int CFG_W        = 8;
    localparam int CFG_OEB      = 0;
    localparam int CFG_INP_DIS  = 1;
    localparam int CFG_DM       = 2;
    localparam int CFG_DM_W     = 3;
    localparam int CFG_IRQ_EN   = 5;
    localparam int CFG_IRQ_FALL = 6;
    localparam int CFG_FILT     = 7;

    // After reset: output driver off, input enabled, dm=001, irq and filter off.
    localparam logic [CFG_W-1:0] CFG_RESET = 8'h05;

endpackage

// File: rtl/mprj_io_pad_cond.sv
// Input conditioning for one pad: synchroniser, optional debounce filter,
// edge detect and a sticky, write-1-to-clear edge flag.
// Ports:
//   clock, resetn   system clock, async active-low reset
//   pad_cin         raw asynchronous pad input
//   filt_en         debounce enable (from the committed config)
//   irq_en          edge flag enable
//   irq_fall        1 = flag falling edges, 0 = rising edges
//   irq_clear       write-1-to-clear for irq_pending
//   io_in           conditioned input
//   irq_pending     sticky edge flag
module mprj_io_pad_cond
    import mprj_io_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4
) (
    input  logic clock,
    input  logic resetn,
    input  logic pad_cin,
    input  logic filt_en,
    input  logic irq_en,
    input  logic irq_fall,
    input  logic irq_clear,
    output logic io_in,
    output logic irq_pending
);

    localparam int CNT_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       filt_cnt;
    logic                   filt_en_q;
    logic                   prev;
    logic                   s;
    logic                   edge_hit;

    assign s = sync_q[SYNC_STAGES-1];

    // prev tracks io_in unconditionally, so enabling irq_en later never
    // sees a stale history and cannot fake an edge.
    assign edge_hit = irq_en & (irq_fall ? (~io_in & prev) : (io_in & ~prev));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q      <= '0;
            filt_cnt    <= '0;
            filt_en_q   <= 1'b0;
            io_in       <= 1'b0;
            prev        <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pad_cin};
            filt_en_q <= filt_en;
            prev      <= io_in;

            // The counter holds the number of consecutive cycles s has
            // disagreed with io_in; a mode change restarts it and freezes io_in.
            if (filt_en != filt_en_q) begin
                filt_cnt <= '0;
            end else if (!filt_en) begin
                io_in    <= s;
                filt_cnt <= '0;
            end else if (s == io_in) begin
                filt_cnt <= '0;
            end else if (filt_cnt == CNT_LAST) begin
                io_in    <= s;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end

            // A new edge wins over a simultaneous clear.
            irq_pending <= (irq_pending & ~irq_clear) | edge_hit;
        end
    end

endmodule

// File: rtl/mprj_io_ctrl.sv
// Per-pad control layer between the core and the pad array.
// Holds a serial configuration chain with atomic commit to the active config,
// drives pad control bits from the active config and conditions pad inputs.
// Ports:
//   clock, resetn          system clock, async active-low reset
//   shift_en, shift_data   shift one bit into the chain LSB
//   shift_out              chain MSB for daisy-chain / readback
//   cfg_load               commit chain to active config
//   cfg_done               one-cycle pulse after each commit
//   pad_cin                raw pad inputs
//   io_in                  conditioned inputs to the core
//   pad_oeb, pad_inp_dis   pad output-enable (active low), input disable
//   pad_dm                 pad drive mode, pad p at [3p+:3]
//   irq_clear              write-1-to-clear per-pad pending flags
//   irq_pending, irq       sticky edge flags and their registered OR
module mprj_io_ctrl
    import mprj_io_ctrl_pkg::*;
#(
    parameter int NUM_PADS    = 38,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  shift_en,
    input  logic                  shift_data,
    output logic                  shift_out,
    input  logic                  cfg_load,
    output logic                  cfg_done,
    input  logic [NUM_PADS-1:0]   pad_cin,
    output logic [NUM_PADS-1:0]   io_in,
    output logic [NUM_PADS-1:0]   pad_oeb,
    output logic [NUM_PADS-1:0]   pad_inp_dis,
    output logic [3*NUM_PADS-1:0] pad_dm,
    input  logic [NUM_PADS-1:0]   irq_clear,
    output logic [NUM_PADS-1:0]   irq_pending,
    output logic                  irq
);

    localparam int CHAIN_W = NUM_PADS * CFG_W;

    logic [CHAIN_W-1:0] chain;
    logic [CHAIN_W-1:0] active_cfg;

    // Commit samples the chain before any same-cycle shift lands.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            chain      <= '0;
            active_cfg <= {NUM_PADS{CFG_RESET}};
            cfg_done   <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (shift_en) begin
                chain <= {chain[CHAIN_W-2:0], shift_data};
            end
            if (cfg_load) begin
                active_cfg <= chain;
            end
            cfg_done <= cfg_load;
            irq      <= |irq_pending;
        end
    end

    assign shift_out = chain[CHAIN_W-1];

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        localparam int B = p * CFG_W;

        assign pad_oeb[p]                 = active_cfg[B + CFG_OEB];
        assign pad_inp_dis[p]             = active_cfg[B + CFG_INP_DIS];
        assign pad_dm[p*CFG_DM_W +: CFG_DM_W] = active_cfg[B + CFG_DM +: CFG_DM_W];

        mprj_io_pad_cond #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYCLES (FILT_CYCLES)
        ) u_cond (
            .clock       (clock),
            .resetn      (resetn),
            .pad_cin     (pad_cin[p]),
            .filt_en     (active_cfg[B + CFG_FILT]),
            .irq_en      (active_cfg[B + CFG_IRQ_EN]),
            .irq_fall    (active_cfg[B + CFG_IRQ_FALL]),
            .irq_clear   (irq_clear[p]),
            .io_in       (io_in[p]),
            .irq_pending (irq_pending[p])
        );
    end

endmodule

// File: tb/tb_mprj_io_ctrl.sv
// Bench for mprj_io_ctrl: a cycle model of the pad layer predicts every output
// after each clock edge; predictions are queued and a monitor compares them.
// Commits additionally queue their chain snapshot, checked when cfg_done fires.
module tb_mprj_io_ctrl;

    localparam int NP  = 38;
    localparam int SS  = 2;
    localparam int FC  = 4;
    localparam int CHW = NP * 8;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic shift_en = 1'b0;
    logic shift_data = 1'b0;
    logic cfg_load = 1'b0;
    logic shift_out, cfg_done, irq;
    logic [NP-1:0]   pad_cin = '0;
    logic [NP-1:0]   irq_clear = '0;
    logic [NP-1:0]   io_in, pad_oeb, pad_inp_dis, irq_pending;
    logic [3*NP-1:0] pad_dm;

    always #5 clock = ~clock;

    mprj_io_ctrl #(.NUM_PADS(NP), .SYNC_STAGES(SS), .FILT_CYCLES(FC)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .shift_en    (shift_en),
        .shift_data  (shift_data),
        .shift_out   (shift_out),
        .cfg_load    (cfg_load),
        .cfg_done    (cfg_done),
        .pad_cin     (pad_cin),
        .io_in       (io_in),
        .pad_oeb     (pad_oeb),
        .pad_inp_dis (pad_inp_dis),
        .pad_dm      (pad_dm),
        .irq_clear   (irq_clear),
        .irq_pending (irq_pending),
        .irq         (irq)
    );

    typedef struct {
        logic [NP-1:0]   io;
        logic [NP-1:0]   oeb;
        logic [NP-1:0]   inp;
        logic [NP-1:0]   pend;
        logic [3*NP-1:0] dm;
        logic            irq;
        logic            done;
        logic            sout;
    } exp_t;

    exp_t           exp_q[$];
    logic [CHW-1:0] cfg_q[$];
    int checks = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Reference model: state after each edge, derived from the behavioural rules.
    logic [CHW-1:0] m_chain;
    logic [7:0]     m_cfg [NP];
    logic [NP-1:0]  m_pipe[$];      // raw samples still inside the synchroniser
    logic [NP-1:0]  m_io, m_prev, m_pend, m_filt_prev;
    int             m_run [NP];     // consecutive cycles synced input disagreed with io
    logic           m_irq, m_done;

    function automatic void model_reset();
        m_chain = '0;
        for (int p = 0; p < NP; p++) begin
            m_cfg[p] = 8'h05;
            m_run[p] = 0;
        end
        m_pipe = {};
        for (int i = 0; i < SS; i++) m_pipe.push_back('0);
        m_io = '0; m_prev = '0; m_pend = '0; m_filt_prev = '0;
        m_irq = 1'b0; m_done = 1'b0;
    endfunction

    function automatic void model_step();
        logic [NP-1:0]  s;
        logic [NP-1:0]  old_io, old_prev, old_pend;
        logic [CHW-1:0] old_chain;
        s = m_pipe[0];
        old_io = m_io; old_prev = m_prev; old_pend = m_pend; old_chain = m_chain;
        for (int p = 0; p < NP; p++) begin
            logic f, rise, fall, hit;
            f = m_cfg[p][7];
            if (f != m_filt_prev[p]) begin
                m_run[p] = 0;
            end else if (!f) begin
                m_io[p] = s[p];
                m_run[p] = 0;
            end else if (s[p] == old_io[p]) begin
                m_run[p] = 0;
            end else begin
                m_run[p]++;
                if (m_run[p] == FC) begin
                    m_io[p] = s[p];
                    m_run[p] = 0;
                end
            end
            m_filt_prev[p] = f;
            rise = old_io[p] & ~old_prev[p];
            fall = ~old_io[p] & old_prev[p];
            hit  = m_cfg[p][5] & (m_cfg[p][6] ? fall : rise);
            m_pend[p] = (old_pend[p] & ~irq_clear[p]) | hit;
        end
        m_prev = old_io;
        m_irq  = |old_pend;
        m_done = cfg_load;
        if (cfg_load)
            for (int p = 0; p < NP; p++) m_cfg[p] = old_chain[p*8 +: 8];
        if (shift_en) m_chain = {old_chain[CHW-2:0], shift_data};
        void'(m_pipe.pop_front());
        m_pipe.push_back(pad_cin);
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        for (int p = 0; p < NP; p++) begin
            e.oeb[p]       = m_cfg[p][0];
            e.inp[p]       = m_cfg[p][1];
            e.dm[3*p +: 3] = m_cfg[p][4:2];
        end
        e.io = m_io; e.pend = m_pend; e.irq = m_irq;
        e.done = m_done; e.sout = m_chain[CHW-1];
        return e;
    endfunction

    // Called with inputs set for the coming edge; returns at the next negedge.
    task automatic cycle();
        if (!resetn) begin
            model_reset();
            cfg_q.delete();
        end else begin
            if (cfg_load) cfg_q.push_back(m_chain);
            model_step();
        end
        exp_q.push_back(model_out());
        @(negedge clock);
    endtask

    initial begin
        exp_t e;
        logic [CHW-1:0]  c;
        logic [NP-1:0]   eo;
        logic [3*NP-1:0] ed;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("io_in",       128'(io_in),       128'(e.io));
                chk("pad_oeb",     128'(pad_oeb),     128'(e.oeb));
                chk("pad_inp_dis", 128'(pad_inp_dis), 128'(e.inp));
                chk("pad_dm",      128'(pad_dm),      128'(e.dm));
                chk("irq_pending", 128'(irq_pending), 128'(e.pend));
                chk("irq",         128'(irq),         128'(e.irq));
                chk("cfg_done",    128'(cfg_done),    128'(e.done));
                chk("shift_out",   128'(shift_out),   128'(e.sout));
            end
            if (cfg_done === 1'b1) begin
                if (cfg_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL cfg_done_unexpected actual=1 required=0");
                end else begin
                    c = cfg_q.pop_front();
                    for (int p = 0; p < NP; p++) begin
                        eo[p]       = c[p*8];
                        ed[3*p +: 3] = c[p*8+2 +: 3];
                    end
                    chk("commit_oeb", 128'(pad_oeb), 128'(eo));
                    chk("commit_dm",  128'(pad_dm),  128'(ed));
                end
            end
        end
    end

    logic last_bits[$];

    task automatic shift_words(input logic [7:0] w [NP], input bit replay);
        int   mism;
        logic nb[$];
        mism = 0;
        for (int p = NP-1; p >= 0; p--) begin
            for (int b = 7; b >= 0; b--) begin
                if (replay && nb.size() < last_bits.size() && shift_out !== last_bits[nb.size()])
                    mism++;
                shift_en   = 1'b1;
                shift_data = w[p][b];
                nb.push_back(w[p][b]);
                cycle();
            end
        end
        shift_en   = 1'b0;
        shift_data = 1'b0;
        if (replay) chk("shift_out_replay", 128'(mism), 128'(0));
        last_bits = nb;
    endtask

    task automatic load_words(input logic [7:0] w [NP], input bit replay);
        shift_words(w, replay);
        cfg_load = 1'b1;
        cycle();
        cfg_load = 1'b0;
    endtask

    function automatic logic [NP-1:0] rnd_bits();
        return NP'({$urandom(), $urandom()});
    endfunction

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=completion");
        finish_run();
    end

    initial begin
        logic [7:0]      wa [NP];
        logic [7:0]      wb [NP];
        logic [7:0]      we [NP];
        logic [3*NP-1:0] rst_dm;
        logic            saw;

        for (int p = 0; p < NP; p++) rst_dm[3*p +: 3] = 3'b001;

        // Reset values
        cycle();
        cycle();
        chk("rst_oeb",       128'(pad_oeb),     128'({NP{1'b1}}));
        chk("rst_dm",        128'(pad_dm),      128'(rst_dm));
        chk("rst_io_in",     128'(io_in),       128'(0));
        chk("rst_irq",       128'(irq),         128'(0));
        chk("rst_cfg_done",  128'(cfg_done),    128'(0));
        chk("rst_shift_out", 128'(shift_out),   128'(0));
        resetn = 1'b1;
        cycle();

        // Full chain load: pad0 = 8'h20, the rest at their reset word
        for (int p = 0; p < NP; p++) wa[p] = 8'h05;
        wa[0] = 8'h20;
        load_words(wa, 1'b0);
        chk("load_oeb0",     128'(pad_oeb[0]),  128'(0));
        chk("load_oeb1",     128'(pad_oeb[1]),  128'(1));
        chk("load_dm0",      128'(pad_dm[2:0]), 128'(0));
        chk("load_done",     128'(cfg_done),    128'(1));
        cycle();
        chk("load_done_end", 128'(cfg_done),    128'(0));

        // Unfiltered input: three-cycle latency
        pad_cin[5] = 1'b1;
        cycle();
        cycle();
        chk("unfilt_lat2", 128'(io_in[5]), 128'(0));
        cycle();
        chk("unfilt_lat3", 128'(io_in[5]), 128'(1));
        pad_cin[5] = 1'b0;
        repeat (5) cycle();

        // Second load replays the first one out of shift_out.
        // pad5: filter on; pad7: rising-edge irq.
        wb = wa;
        wb[5] = 8'h85;
        wb[7] = 8'h25;
        load_words(wb, 1'b1);
        repeat (3) cycle();

        // Filtered: a 3-cycle pulse is swallowed
        saw = 1'b0;
        pad_cin[5] = 1'b1;
        repeat (3) begin cycle(); saw |= io_in[5]; end
        pad_cin[5] = 1'b0;
        repeat (8) begin cycle(); saw |= io_in[5]; end
        chk("filt_glitch", 128'(saw), 128'(0));

        // Filtered: 6-cycle high passes once stable for 4 cycles
        pad_cin[5] = 1'b1;
        repeat (5) cycle();
        chk("filt_pass5", 128'(io_in[5]), 128'(0));
        cycle();
        chk("filt_pass6", 128'(io_in[5]), 128'(1));
        pad_cin[5] = 1'b0;
        repeat (10) cycle();
        chk("filt_fall", 128'(io_in[5]), 128'(0));

        // Edge interrupt on pad 7
        pad_cin[7] = 1'b1;
        repeat (4) cycle();
        chk("irq_pend_set", 128'(irq_pending[7]), 128'(1));
        chk("irq_lag",      128'(irq),            128'(0));
        cycle();
        chk("irq_set",      128'(irq),            128'(1));
        irq_clear[7] = 1'b1;
        cycle();
        irq_clear[7] = 1'b0;
        chk("irq_clear",    128'(irq_pending[7]), 128'(0));
        pad_cin[7] = 1'b0;
        repeat (6) cycle();
        chk("irq_fall_ign", 128'(irq_pending[7]), 128'(0));
        pad_cin[7] = 1'b1;
        repeat (3) cycle();
        irq_clear[7] = 1'b1;
        cycle();
        irq_clear[7] = 1'b0;
        chk("irq_set_wins", 128'(irq_pending[7]), 128'(1));
        irq_clear[7] = 1'b1;
        cycle();
        irq_clear[7] = 1'b0;
        pad_cin[7] = 1'b0;
        repeat (6) cycle();

        // Commit with a same-cycle shift takes the pre-shift chain
        we = wb;
        we[0] = 8'h1C;
        shift_words(we, 1'b0);
        shift_en   = 1'b1;
        shift_data = 1'b1;
        cfg_load   = 1'b1;
        cycle();
        shift_en   = 1'b0;
        shift_data = 1'b0;
        cfg_load   = 1'b0;
        chk("load_shift_dm0",  128'(pad_dm[2:0]), 128'(3'b111));
        chk("load_shift_oeb0", 128'(pad_oeb[0]),  128'(0));
        cycle();

        // Reset in the middle of a shift
        shift_en = 1'b1;
        repeat (100) begin
            shift_data = 1'($urandom_range(0, 1));
            cycle();
        end
        resetn = 1'b0;
        #1;
        chk("midrst_oeb",   128'(pad_oeb),     128'({NP{1'b1}}));
        chk("midrst_dm",    128'(pad_dm),      128'(rst_dm));
        chk("midrst_sout",  128'(shift_out),   128'(0));
        chk("midrst_pend",  128'(irq_pending), 128'(0));
        cycle();
        shift_en   = 1'b0;
        shift_data = 1'b0;
        resetn = 1'b1;
        cycle();
        last_bits = {};

        // Randomised traffic against the model
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < NP; p++) wa[p] = 8'($urandom());
            load_words(wa, 1'b0);
            for (int i = 0; i < 400; i++) begin
                pad_cin    = pad_cin ^ (rnd_bits() & rnd_bits() & rnd_bits());
                irq_clear  = rnd_bits() & rnd_bits() & rnd_bits();
                shift_en   = ($urandom_range(0, 15) == 0);
                shift_data = 1'($urandom_range(0, 1));
                cfg_load   = ($urandom_range(0, 63) == 0);
                cycle();
            end
            pad_cin = '0; irq_clear = '0; shift_en = 1'b0; cfg_load = 1'b0;
            repeat (12) cycle();
        end

        repeat (4) cycle();
        chk("cfg_q_drained", 128'(cfg_q.size()), 128'(0));
        chk("exp_q_drained", 128'(exp_q.size()), 128'(0));
        finish_run();
    end

endmodule
